// File: rtl/pio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pio_pkg : register map and edge-type constants for the input PIO   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pio_pkg;

  localparam logic [1:0] PIO_DATA = 2'd0;
  localparam logic [1:0] PIO_RSVD = 2'd1;
  localparam logic [1:0] PIO_MASK = 2'd2;
  localparam logic [1:0] PIO_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Operates on 32-bit vectors so any WIDTH up to 32 can share it.
  function automatic logic [31:0] edge_events(input int edge_type,
                                              input logic [31:0] cur,
                                              input logic [31:0] prev);
    logic [31:0] evt;
    if (edge_type == EDGE_FALL)
      evt = ~cur & prev;
    else if (edge_type == EDGE_ANY)
      evt = cur ^ prev;
    else
      evt = cur & ~prev;
    return evt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pio_input_irq_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pio_input_irq_if : Avalon-MM slave bus bundle for the input PIO    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface pio_input_irq_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface
`default_nettype wire

// File: rtl/pio_debounce_bit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pio_debounce_bit : per-bit synchroniser chain and debounce filter  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pio_debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic stable
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync_bit;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_bit};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= sync_d;
  end

  assign sync_bit = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign stable = sync_bit;
    end else begin : g_debounce
      localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          stable_q;
      logic          stable_d;

      // The cycle where the count would reach N is the one that commits the new level.
      always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_bit == stable_q) begin
          cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
          stable_d = sync_bit;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q    <= '0;
          stable_q <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          stable_q <= stable_d;
        end
      end

      assign stable = stable_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/pio_input_irq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pio_input_irq : Avalon-MM input PIO with edge capture and IRQ      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pio_input_irq
  import pio_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  pio_input_irq_if.slave   bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_debounce_bit #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
        .clk     (clk),
        .reset_n (reset_n),
        .in_bit  (in_port[i]),
        .stable  (stable[i])
      );
    end
  endgenerate

  logic [WIDTH-1:0] prev_q,     prev_d;
  logic [WIDTH-1:0] irqmask_q,  irqmask_d;
  logic [WIDTH-1:0] edgecap_q,  edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] clr;
  logic             wr_en;

  always_comb begin
    wr_en    = bus.chipselect && !bus.write_n;
    edge_evt = WIDTH'(edge_events(EDGE_TYPE, 32'(stable), 32'(prev_q)));
    prev_d   = stable;

    irqmask_d = irqmask_q;
    if (wr_en && (bus.address == PIO_MASK)) irqmask_d = bus.writedata[WIDTH-1:0];

    clr = '0;
    if (wr_en && (bus.address == PIO_EDGE)) clr = bus.writedata[WIDTH-1:0];

    // Set is ORed in after the clear so a simultaneous edge is never lost.
    edgecap_d = (edgecap_q & ~clr) | edge_evt;

    case (bus.address)
      PIO_DATA: readdata_d = 32'(stable);
      PIO_MASK: readdata_d = 32'(irqmask_q);
      PIO_EDGE: readdata_d = 32'(edgecap_q);
      default:  readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      prev_q     <= prev_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = |(edgecap_q & irqmask_q);

  generate
    if (WIDTH < 32) begin : g_unused_wd
      logic unused_wd;
      assign unused_wd = ^bus.writedata[31:WIDTH];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pio_input_irq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pio_input_irq : two PIO configurations against a spec model     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pio_input_irq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] in_port;
  logic       irq0, irq1;

  always #5 clk = ~clk;

  pio_input_irq_if bus0 ();
  pio_input_irq_if bus1 ();

  assign bus1.address    = bus0.address;
  assign bus1.chipselect = bus0.chipselect;
  assign bus1.write_n    = bus0.write_n;
  assign bus1.writedata  = bus0.writedata;

  pio_input_irq #(.WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port), .irq(irq0));

  pio_input_irq #(.WIDTH(10), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_port), .irq(irq1));

  // Reference model: input delay line, history window of synchronised samples.
  int         P_SYNC [2] = '{2, 3};
  int         P_DEB  [2] = '{0, 4};
  int         P_EDGE [2] = '{0, 2};
  logic [9:0] m_pipe [2][4];
  logic [9:0] m_hist [2][4];
  logic [9:0] m_stable [2];
  logic [9:0] m_prev [2];
  logic [9:0] m_mask [2];
  logic [9:0] m_cap [2];
  logic [31:0] m_rd [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic m_zero(input int d);
    for (int k = 0; k < 4; k++) begin
      m_pipe[d][k] = '0;
      m_hist[d][k] = '0;
    end
    m_stable[d] = '0;
    m_prev[d]   = '0;
    m_mask[d]   = '0;
    m_cap[d]    = '0;
    m_rd[d]     = '0;
  endtask

  function automatic logic m_irq(input int d);
    return |(m_cap[d] & m_mask[d]);
  endfunction

  task automatic m_step(input int d);
    logic [9:0] s, st, evt, clr, stn, smp;
    logic       all_diff;
    logic       wr;
    if (!reset_n) begin
      m_zero(d);
      return;
    end
    s  = m_pipe[d][P_SYNC[d]-1];
    st = (P_DEB[d] == 0) ? s : m_stable[d];
    case (P_EDGE[d])
      0:       evt = st & ~m_prev[d];
      1:       evt = ~st & m_prev[d];
      default: evt = st ^ m_prev[d];
    endcase
    wr  = bus0.chipselect && !bus0.write_n;
    clr = (wr && bus0.address == 2'd3) ? bus0.writedata[9:0] : 10'h0;
    case (bus0.address)
      2'd0:    m_rd[d] = {22'h0, st};
      2'd2:    m_rd[d] = {22'h0, m_mask[d]};
      2'd3:    m_rd[d] = {22'h0, m_cap[d]};
      default: m_rd[d] = 32'h0;
    endcase
    // A bit is accepted once the last N synchronised samples all disagree with it.
    stn = m_stable[d];
    if (P_DEB[d] > 0) begin
      for (int b = 0; b < 10; b++) begin
        all_diff = 1'b1;
        for (int k = 0; k < P_DEB[d]; k++) begin
          smp = (k == 0) ? s : m_hist[d][k-1];
          if (smp[b] == m_stable[d][b]) all_diff = 1'b0;
        end
        if (all_diff) stn[b] = s[b];
      end
      for (int k = 3; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
      m_hist[d][0] = s;
    end
    m_cap[d] = (m_cap[d] & ~clr) | evt;
    if (wr && bus0.address == 2'd2) m_mask[d] = bus0.writedata[9:0];
    m_stable[d] = stn;
    m_prev[d]   = st;
    for (int k = 3; k > 0; k--) m_pipe[d][k] = m_pipe[d][k-1];
    m_pipe[d][0] = in_port;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    m_step(0);
    m_step(1);
    #1;
    chk("rd0",  bus0.readdata, m_rd[0]);
    chk("rd1",  bus1.readdata, m_rd[1]);
    chk("irq0", {31'h0, irq0}, {31'h0, m_irq(0)});
    chk("irq1", {31'h0, irq1}, {31'h0, m_irq(1)});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] wd);
    bus0.chipselect = 1'b1;
    bus0.write_n    = 1'b0;
    bus0.address    = a;
    bus0.writedata  = wd;
    tick();
    bus0.chipselect = 1'b0;
    bus0.write_n    = 1'b1;
  endtask

  initial begin
    reset_n         = 1'b0;
    in_port         = 10'h3FF;
    bus0.address    = 2'd0;
    bus0.chipselect = 1'b0;
    bus0.write_n    = 1'b1;
    bus0.writedata  = '0;
    m_zero(0);
    m_zero(1);

    // Reset with all inputs high, then data visible three edges after release
    ticks(2);
    chk("reset_rd0",  bus0.readdata, 32'h0);
    chk("reset_irq0", {31'h0, irq0}, 32'h0);
    reset_n = 1'b1;
    ticks(3);
    chk("data_3ff", bus0.readdata, 32'h3FF);

    // Rising edge on bit 0, irq timing, then W1C clear
    in_port = 10'h000;
    ticks(12);
    bus_wr(2'd2, 32'h1);
    bus_wr(2'd3, 32'h3FF);
    bus0.address = 2'd3;
    ticks(12);
    in_port[0] = 1'b1;
    ticks(2);
    chk("irq_early", {31'h0, irq0}, 32'h0);
    tick();
    chk("irq_set", {31'h0, irq0}, 32'h1);
    tick();
    chk("cap_rd", bus0.readdata, 32'h1);
    bus_wr(2'd3, 32'h1);
    chk("irq_clr", {31'h0, irq0}, 32'h0);

    // Clear and set on the same edge: set wins
    in_port[0] = 1'b0;
    ticks(6);
    in_port[0] = 1'b1;
    ticks(2);
    bus_wr(2'd3, 32'h1);
    chk("set_wins", {31'h0, irq0}, 32'h1);
    ticks(2);
    chk("set_wins_rd", bus0.readdata & 32'h1, 32'h1);

    // Debounce on the N=4 instance: short pulse rejected, long level accepted
    bus0.address = 2'd0;
    ticks(12);
    in_port[5] = 1'b1;
    ticks(3);
    in_port[5] = 1'b0;
    ticks(10);
    chk("pulse_rej", bus1.readdata & 32'h20, 32'h0);
    in_port[5] = 1'b1;
    ticks(9);
    chk("level_acc", bus1.readdata & 32'h20, 32'h20);
    in_port[5] = 1'b0;
    ticks(10);

    // Any-edge capture with mask off, then mask on raises irq
    in_port[9] = 1'b1;
    ticks(12);
    bus_wr(2'd2, 32'h0);
    bus_wr(2'd3, 32'h3FF);
    in_port[9] = 1'b0;
    ticks(12);
    bus0.address = 2'd3;
    tick();
    chk("any_cap", bus1.readdata, 32'h200);
    chk("any_noirq", {31'h0, irq1}, 32'h0);
    bus_wr(2'd2, 32'h200);
    chk("any_irq", {31'h0, irq1}, 32'h1);

    // Asynchronous reset mid-count with captured edges pending
    in_port = 10'h000;
    ticks(12);
    bus_wr(2'd3, 32'h3FF);
    bus_wr(2'd2, 32'h3FF);
    in_port = 10'h00F;
    ticks(5);
    reset_n = 1'b0;
    #1;
    m_zero(0);
    m_zero(1);
    chk("arst_rd0",  bus0.readdata, 32'h0);
    chk("arst_rd1",  bus1.readdata, 32'h0);
    chk("arst_irq0", {31'h0, irq0}, 32'h0);
    chk("arst_irq1", {31'h0, irq1}, 32'h0);
    in_port = 10'h000;
    ticks(2);
    reset_n = 1'b1;
    ticks(20);
    chk("no_spur0", bus0.readdata, 32'h0);
    chk("no_spur1", bus1.readdata, 32'h0);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) in_port = in_port ^ 10'($urandom);
      bus0.chipselect = 1'($urandom_range(0, 1));
      bus0.write_n    = ($urandom_range(0, 2) != 0);
      bus0.address    = 2'($urandom);
      bus0.writedata  = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
